id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register with an integrated load-use interlock for the 5-stage MIPS core. It captures the decoded instruction, PC, operand values and write/read-class flags from the ID stage. Its registered `ID_EX_*` outputs feed the EX stage and the ID/EX rs/rt forwarding units. Loads write rt only in the `isW_rt_2` class, which is forwardable only from MEM/WB, so this block inserts the single bubble a load-use pair needs. It also applies flush and external stall.

## Interface
- `CNT_W`, 16, width of the saturating load-use stall counter
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `IF_ID_Instr`  in  32  instruction in ID
- `IF_ID_PC`  in  32  PC+4 of that instruction
- `IF_ID_rs_data`, `IF_ID_rt_data`  in  32 each  register-file read values
- `IF_ID_isR_s_1`, `IF_ID_isR_t_1`  in  1 each  instruction reads rs / rt
- `IF_ID_isW_rd_1`, `IF_ID_isW_rt_1`, `IF_ID_isW_31_rd_0`, `IF_ID_isW_rt_2`  in  1 each  write-class flags (ALU rd, ALU-imm rt, link 31/rd, load rt)
- `flush`  in  1  branch/jump redirect resolved; ID instruction is wrong-path
- `ext_stall`  in  1  EX busy (mult/div); hold ID/EX
- `ID_EX_Instr`, `ID_EX_PC`, `ID_EX_rs_data`, `ID_EX_rt_data`  out  32 each  registered copies
- `ID_EX_isR_s_1`, `ID_EX_isR_t_1`, `ID_EX_isW_rd_1`, `ID_EX_isW_rt_1`, `ID_EX_isW_31_rd_0`, `ID_EX_isW_rt_2`  out  1 each  registered flags
- `ID_EX_valid`  out  1  1 = real instruction, 0 = bubble
- `IF_ID_stall`  out  1  combinational; hold PC and IF/ID this cycle
- `lu_stall_cnt`  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Define `load_use` = `ID_EX_valid` and `ID_EX_isW_rt_2` and `ID_EX_Instr[20:16]` != 0, and one of the following:
  - `IF_ID_isR_s_1` and `IF_ID_Instr[25:21]` == `ID_EX_Instr[20:16]`
  - `IF_ID_isR_t_1` and `IF_ID_Instr[20:16]` == `ID_EX_Instr[20:16]`
- Next-state selection, priority highest first:
  - `rst`: load bubble, counter = 0.
  - `flush`: load bubble; `IF_ID_stall` = 0.
  - `ext_stall`: hold all ID/EX state; `IF_ID_stall` = 1.
  - `load_use`: load bubble; `IF_ID_stall` = 1; counter += 1, saturating at all-ones.
  - Otherwise: capture all `IF_ID_*` inputs, `ID_EX_valid` = 1; `IF_ID_stall` = 0.
- A bubble means:
  - `ID_EX_Instr` = 32'h0000_0000 (sll $0,$0,0)
  - PC and data = 0
  - all flags = 0
  - `ID_EX_valid` = 0
- The interlock is implicit two-state: NORMAL, and BUBBLE after a load-use. A bubble clears `ID_EX_isW_rt_2`, so `load_use` cannot assert on the next cycle; the held instruction then advances. Exactly one bubble is inserted per load-use pair.
- `ext_stall` together with `load_use`: hold wins. The pending load stays in ID/EX and `load_use` is re-evaluated after release.
- `flush` together with `load_use`: flush wins. No counter increment.

## Timing
- Reset values: all `ID_EX_*` = 0, `ID_EX_valid` = 0, `lu_stall_cnt` = 0.
- `IF_ID_stall` is 0 whenever `rst` = 1.
- Latency: inputs appear on `ID_EX_*` one cycle after capture.
- `IF_ID_stall` is a same-cycle combinational function of current registered state plus `IF_ID_*` flags, `flush`, `ext_stall` and `rst`. It has no path from `*_data` inputs.
- Counter updates on the same edge as the bubble load.
- Reset asserted mid-stall clears state on the next edge. No bubble is owed after reset deassertion.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` = 32'h0
  - field positions: `RS_MSB/LSB` = 25/21, `RT_MSB/LSB` = 20/16, `RD_MSB/LSB` = 15/11
  - a packed `id_ex_flags_t` (6 flag bits, order as listed above); the forwarding units already consume these
- One combinational sub-module, `load_use_det`. Its inputs are the ID/EX rt index, `ID_EX_valid`, `ID_EX_isW_rt_2`, the IF/ID rs/rt indices and the IF/ID read flags. Its output is `load_use`.
- The register, priority mux and counter stay in the top module.

## Test plan
- Reset then plain stream: `add $3,$1,$2` at PC 4 → `ID_EX_Instr` = 32'h0022_1820 and `ID_EX_valid` = 1 one cycle later; `IF_ID_stall` stays 0.
- Load-use: `lw $5,0($1)` in ID/EX, `add $6,$5,$2` in ID with `isR_s_1` = 1 → `IF_ID_stall` = 1 for exactly one cycle, then a bubble (Instr 0, valid 0); the next cycle captures the add; `lu_stall_cnt` = 1.
- No false stall:
  - `lw $0,0($1)` followed by a read of $0 → no stall
  - `lw $5` followed by an instruction with `isR_t_1` = 0 and rt = 5 → no stall
- `ext_stall` held 3 cycles with a lw in ID/EX and a dependent instruction in ID → ID/EX unchanged and `IF_ID_stall` = 1 throughout. After release, exactly one bubble and the counter increments by 1.
- `flush` coincident with `load_use` → bubble loaded, `IF_ID_stall` = 0, counter unchanged.
- Force the counter to all-ones minus 1, then trigger two load-use events → counter saturates at 16'hFFFF; `rst` mid-bubble → all outputs 0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: NOP encoding, instruction field positions and
// the ID/EX flag bundle consumed by the EX stage and the forwarding units.
package id_ex_stage_reg_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // Read-class and write-class flags, MSB first in the order they are listed
    typedef struct packed {
        logic isR_s_1;
        logic isR_t_1;
        logic isW_rd_1;
        logic isW_rt_1;
        logic isW_31_rd_0;
        logic isW_rt_2;
    } id_ex_flags_t;

    localparam id_ex_flags_t NO_FLAGS = '0;

    function automatic logic [4:0] rsField(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rtField(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_det.sv
// Load-use hazard detector: a load in ID/EX writing a nonzero rt that the
// instruction in ID reads through rs or rt needs one bubble, because the
// loaded value is only forwardable from MEM/WB.
module load_use_det
    import id_ex_stage_reg_pkg::*;
(
    input  logic [4:0] exRt,
    input  logic       exValid,
    input  logic       exIsWrt2,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idIsRs,
    input  logic       idIsRt,
    output logic       loadUse
);

    logic exIsLoad;
    logic rsHit;
    logic rtHit;

    // Hazard exists only for a live load targeting a real (nonzero) register
    always_comb begin
        exIsLoad = exValid && exIsWrt2 && (exRt != 5'd0);
        rsHit    = idIsRs && (idRs == exRt);
        rtHit    = idIsRt && (idRt == exRt);
        loadUse  = exIsLoad && (rsHit || rtHit);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use interlock, flush and external stall.
// Priority on each edge: reset, flush, external hold, load-use bubble, capture.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_ID_Instr,
    input  logic [31:0]      IF_ID_PC,
    input  logic [31:0]      IF_ID_rs_data,
    input  logic [31:0]      IF_ID_rt_data,
    input  logic             IF_ID_isR_s_1,
    input  logic             IF_ID_isR_t_1,
    input  logic             IF_ID_isW_rd_1,
    input  logic             IF_ID_isW_rt_1,
    input  logic             IF_ID_isW_31_rd_0,
    input  logic             IF_ID_isW_rt_2,
    input  logic             flush,
    input  logic             ext_stall,
    output logic [31:0]      ID_EX_Instr,
    output logic [31:0]      ID_EX_PC,
    output logic [31:0]      ID_EX_rs_data,
    output logic [31:0]      ID_EX_rt_data,
    output logic             ID_EX_isR_s_1,
    output logic             ID_EX_isR_t_1,
    output logic             ID_EX_isW_rd_1,
    output logic             ID_EX_isW_rt_1,
    output logic             ID_EX_isW_31_rd_0,
    output logic             ID_EX_isW_rt_2,
    output logic             ID_EX_valid,
    output logic             IF_ID_stall,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    id_ex_flags_t      flagsIn;
    id_ex_flags_t      flags_p1;
    logic [31:0]       instr_p1;
    logic [31:0]       pc_p1;
    logic [31:0]       rsData_p1;
    logic [31:0]       rtData_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  luCnt;
    logic              loadUse;

    // Bundle the incoming ID flags in the shared packed order
    always_comb begin
        flagsIn = '{
            isR_s_1:     IF_ID_isR_s_1,
            isR_t_1:     IF_ID_isR_t_1,
            isW_rd_1:    IF_ID_isW_rd_1,
            isW_rt_1:    IF_ID_isW_rt_1,
            isW_31_rd_0: IF_ID_isW_31_rd_0,
            isW_rt_2:    IF_ID_isW_rt_2
        };
    end

    load_use_det uDet (
        .exRt     (rtField(instr_p1)),
        .exValid  (vld_p1),
        .exIsWrt2 (flags_p1.isW_rt_2),
        .idRs     (rsField(IF_ID_Instr)),
        .idRt     (rtField(IF_ID_Instr)),
        .idIsRs   (IF_ID_isR_s_1),
        .idIsRt   (IF_ID_isR_t_1),
        .loadUse  (loadUse)
    );

    // Hold IF/ID while EX is busy or a load-use bubble is being inserted;
    // reset and flush both discard the ID instruction, so never hold then
    always_comb begin
        IF_ID_stall = !rst && !flush && (ext_stall || loadUse);
    end

    // ---- ID -> EX stage boundary ----
    // Priority register update plus saturating count of load-use bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1  <= NOP_INSTR;
            pc_p1     <= '0;
            rsData_p1 <= '0;
            rtData_p1 <= '0;
            flags_p1  <= NO_FLAGS;
            vld_p1    <= 1'b0;
            luCnt     <= '0;
        end else if (flush) begin
            instr_p1  <= NOP_INSTR;
            pc_p1     <= '0;
            rsData_p1 <= '0;
            rtData_p1 <= '0;
            flags_p1  <= NO_FLAGS;
            vld_p1    <= 1'b0;
        end else if (ext_stall) begin
            // Hold: ID/EX keeps the instruction EX is still working on
            instr_p1  <= instr_p1;
        end else if (loadUse) begin
            instr_p1  <= NOP_INSTR;
            pc_p1     <= '0;
            rsData_p1 <= '0;
            rtData_p1 <= '0;
            flags_p1  <= NO_FLAGS;
            vld_p1    <= 1'b0;
            luCnt     <= satInc(luCnt);
        end else begin
            instr_p1  <= IF_ID_Instr;
            pc_p1     <= IF_ID_PC;
            rsData_p1 <= IF_ID_rs_data;
            rtData_p1 <= IF_ID_rt_data;
            flags_p1  <= flagsIn;
            vld_p1    <= 1'b1;
        end
    end

    assign ID_EX_Instr       = instr_p1;
    assign ID_EX_PC          = pc_p1;
    assign ID_EX_rs_data     = rsData_p1;
    assign ID_EX_rt_data     = rtData_p1;
    assign ID_EX_isR_s_1     = flags_p1.isR_s_1;
    assign ID_EX_isR_t_1     = flags_p1.isR_t_1;
    assign ID_EX_isW_rd_1    = flags_p1.isW_rd_1;
    assign ID_EX_isW_rt_1    = flags_p1.isW_rt_1;
    assign ID_EX_isW_31_rd_0 = flags_p1.isW_31_rd_0;
    assign ID_EX_isW_rt_2    = flags_p1.isW_rt_2;
    assign ID_EX_valid       = vld_p1;
    assign lu_stall_cnt      = luCnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg. A second instance with a 2-bit counter
// shares the stimulus so counter saturation is reached in a few events.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rsData, rtData;
    logic [5:0]  fl;    // {isR_s_1,isR_t_1,isW_rd_1,isW_rt_1,isW_31_rd_0,isW_rt_2}
    logic        flush, extStall;

    logic [31:0] oInstr, oPc, oRs, oRt;
    logic [5:0]  oFl;
    logic        oValid, oStall;
    logic [15:0] oCnt;

    logic [31:0] sInstr, sPc, sRs, sRt;
    logic [5:0]  sFl;
    logic        sValid, sStall;
    logic [1:0]  sCnt;

    int nAsserts = 0;
    int nFail    = 0;

    localparam logic [31:0] ADD3   = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] LW5    = 32'h8C25_0000; // lw $5,0($1)
    localparam logic [31:0] ADD6   = 32'h00A2_3020; // add $6,$5,$2
    localparam logic [31:0] LW0    = 32'h8C20_0000; // lw $0,0($1)
    localparam logic [31:0] ADD7   = 32'h0002_3820; // add $7,$0,$2
    localparam logic [31:0] ADDI5  = 32'h2025_0001; // addi $5,$1,1
    localparam logic [5:0]  F_R    = 6'b111000;
    localparam logic [5:0]  F_LW   = 6'b100001;
    localparam logic [5:0]  F_I    = 6'b100100;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_Instr(instr), .IF_ID_PC(pc),
        .IF_ID_rs_data(rsData), .IF_ID_rt_data(rtData),
        .IF_ID_isR_s_1(fl[5]), .IF_ID_isR_t_1(fl[4]), .IF_ID_isW_rd_1(fl[3]),
        .IF_ID_isW_rt_1(fl[2]), .IF_ID_isW_31_rd_0(fl[1]), .IF_ID_isW_rt_2(fl[0]),
        .flush(flush), .ext_stall(extStall),
        .ID_EX_Instr(oInstr), .ID_EX_PC(oPc),
        .ID_EX_rs_data(oRs), .ID_EX_rt_data(oRt),
        .ID_EX_isR_s_1(oFl[5]), .ID_EX_isR_t_1(oFl[4]), .ID_EX_isW_rd_1(oFl[3]),
        .ID_EX_isW_rt_1(oFl[2]), .ID_EX_isW_31_rd_0(oFl[1]), .ID_EX_isW_rt_2(oFl[0]),
        .ID_EX_valid(oValid), .IF_ID_stall(oStall), .lu_stall_cnt(oCnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst),
        .IF_ID_Instr(instr), .IF_ID_PC(pc),
        .IF_ID_rs_data(rsData), .IF_ID_rt_data(rtData),
        .IF_ID_isR_s_1(fl[5]), .IF_ID_isR_t_1(fl[4]), .IF_ID_isW_rd_1(fl[3]),
        .IF_ID_isW_rt_1(fl[2]), .IF_ID_isW_31_rd_0(fl[1]), .IF_ID_isW_rt_2(fl[0]),
        .flush(flush), .ext_stall(extStall),
        .ID_EX_Instr(sInstr), .ID_EX_PC(sPc),
        .ID_EX_rs_data(sRs), .ID_EX_rt_data(sRt),
        .ID_EX_isR_s_1(sFl[5]), .ID_EX_isR_t_1(sFl[4]), .ID_EX_isW_rd_1(sFl[3]),
        .ID_EX_isW_rt_1(sFl[2]), .ID_EX_isW_31_rd_0(sFl[1]), .ID_EX_isW_rt_2(sFl[0]),
        .ID_EX_valid(sValid), .IF_ID_stall(sStall), .lu_stall_cnt(sCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply ID inputs just after an edge, let them settle
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f);
        instr = i; pc = p; rsData = a; rtData = b; fl = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkBubble(input string tag);
        chk({tag, "_instr"}, oInstr, 32'h0);
        chk({tag, "_pc"},    oPc,    32'h0);
        chk({tag, "_rs"},    oRs,    32'h0);
        chk({tag, "_flags"}, {26'h0, oFl}, 32'h0);
        chk({tag, "_valid"}, {31'h0, oValid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; extStall = 1'b0;
        instr = ADD3; pc = 32'h4; rsData = 32'h11; rtData = 32'h22; fl = F_R;

        // Reset
        #1;
        chk("rst_stall", {31'h0, oStall}, 32'h0);
        tick();
        chkBubble("rst");
        chk("rst_cnt", {16'h0, oCnt}, 32'h0);
        chk("rst_cntS", {30'h0, sCnt}, 32'h0);

        // Plain add
        rst = 1'b0;
        drive(ADD3, 32'h4, 32'h11, 32'h22, F_R);
        chk("add_stall", {31'h0, oStall}, 32'h0);
        tick();
        chk("add_instr", oInstr, 32'h0022_1820);
        chk("add_pc", oPc, 32'h4);
        chk("add_rs", oRs, 32'h11);
        chk("add_rt", oRt, 32'h22);
        chk("add_flags", {26'h0, oFl}, {26'h0, F_R});
        chk("add_valid", {31'h0, oValid}, 32'h1);

        // Load-use: lw $5 then add $6,$5,$2
        drive(LW5, 32'h8, 32'h33, 32'h44, F_LW);
        chk("lw_stall", {31'h0, oStall}, 32'h0);
        tick();
        chk("lw_instr", oInstr, LW5);
        drive(ADD6, 32'hC, 32'h55, 32'h66, F_R);
        chk("lu_stall", {31'h0, oStall}, 32'h1);
        tick();
        chkBubble("lu_bubble");
        chk("lu_cnt", {16'h0, oCnt}, 32'h1);
        chk("lu_stall2", {31'h0, oStall}, 32'h0);
        tick();
        chk("lu_adv_instr", oInstr, ADD6);
        chk("lu_adv_pc", oPc, 32'hC);
        chk("lu_adv_valid", {31'h0, oValid}, 32'h1);
        chk("lu_adv_cnt", {16'h0, oCnt}, 32'h1);

        // lw $0 then a reader of $0: no stall
        drive(LW0, 32'h10, 32'h0, 32'h0, F_LW);
        tick();
        drive(ADD7, 32'h14, 32'h0, 32'h77, F_R);
        chk("lw0_stall", {31'h0, oStall}, 32'h0);
        tick();
        chk("lw0_instr", oInstr, ADD7);

        // lw $5 then addi with rt=5 but no rt read: no stall
        drive(LW5, 32'h18, 32'h1, 32'h2, F_LW);
        tick();
        drive(ADDI5, 32'h1C, 32'h3, 32'h4, F_I);
        chk("nort_stall", {31'h0, oStall}, 32'h0);
        tick();
        chk("nort_instr", oInstr, ADDI5);
        chk("nort_flags", {26'h0, oFl}, {26'h0, F_I});

        // ext_stall for 3 cycles over a load-use pair
        drive(LW5, 32'h20, 32'hA, 32'hB, F_LW);
        tick();
        drive(ADD6, 32'h24, 32'hC, 32'hD, F_R);
        extStall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("xs_stall", {31'h0, oStall}, 32'h1);
            tick();
            chk("xs_instr", oInstr, LW5);
            chk("xs_pc", oPc, 32'h20);
            chk("xs_valid", {31'h0, oValid}, 32'h1);
            chk("xs_cnt", {16'h0, oCnt}, 32'h1);
        end
        extStall = 1'b0;
        #1;
        chk("xs_rel_stall", {31'h0, oStall}, 32'h1);
        tick();
        chkBubble("xs_bubble");
        chk("xs_rel_cnt", {16'h0, oCnt}, 32'h2);
        chk("xs_adv_stall", {31'h0, oStall}, 32'h0);
        tick();
        chk("xs_adv_instr", oInstr, ADD6);
        chk("xs_adv_cnt", {16'h0, oCnt}, 32'h2);

        // flush coincident with load-use
        drive(LW5, 32'h28, 32'h1, 32'h1, F_LW);
        tick();
        drive(ADD6, 32'h2C, 32'h2, 32'h2, F_R);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'h0, oStall}, 32'h0);
        tick();
        chkBubble("fl_bubble");
        chk("fl_cnt", {16'h0, oCnt}, 32'h2);
        chk("fl_cntS", {30'h0, sCnt}, 32'h2);
        flush = 1'b0;

        // Two more load-use events: small counter saturates at 2'b11
        drive(LW5, 32'h30, 32'h1, 32'h1, F_LW);
        tick();
        drive(ADD6, 32'h34, 32'h2, 32'h2, F_R);
        tick();
        chk("sat1_cnt", {16'h0, oCnt}, 32'h3);
        chk("sat1_cntS", {30'h0, sCnt}, 32'h3);
        tick();
        drive(LW5, 32'h38, 32'h1, 32'h1, F_LW);
        tick();
        drive(ADD6, 32'h3C, 32'h2, 32'h2, F_R);
        chk("sat2_stallS", {31'h0, sStall}, 32'h1);
        tick();
        chk("sat2_cnt", {16'h0, oCnt}, 32'h4);
        chk("sat2_cntS", {30'h0, sCnt}, 32'h3);
        chk("sat2_validS", {31'h0, sValid}, 32'h0);
        tick();

        // Reset while a load-use is pending
        drive(LW5, 32'h40, 32'h1, 32'h1, F_LW);
        tick();
        drive(ADD6, 32'h44, 32'h9, 32'h8, F_R);
        rst = 1'b1;
        #1;
        chk("rlu_stall", {31'h0, oStall}, 32'h0);
        tick();
        chkBubble("rlu");
        chk("rlu_cnt", {16'h0, oCnt}, 32'h0);
        chk("rlu_cntS", {30'h0, sCnt}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rlu_nobubble", {31'h0, oStall}, 32'h0);
        tick();
        chk("rlu_adv_instr", oInstr, ADD6);
        chk("rlu_adv_rs", oRs, 32'h9);
        chk("rlu_adv_valid", {31'h0, oValid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
